// File: rtl/boom_config_master.sv
// Initiator for the per-core configuration register interface: single read/write
// requests become one-cycle config strobes, plus a built-in core boot sequencer.
module boom_config_master #(
    parameter int                           TCU_REG_ADDR_SIZE = 32,
    parameter int                           TCU_REG_DATA_SIZE = 64,
    parameter int                           TCU_REG_BSEL_SIZE = 8,
    parameter int                           READ_LATENCY      = 1,
    parameter int                           INT1_PULSE_CYCLES = 16,
    parameter logic [TCU_REG_ADDR_SIZE-1:0] REG_EN_ADDR       = 'h0,
    parameter logic [TCU_REG_ADDR_SIZE-1:0] REG_INT1_ADDR     = 'h8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [TCU_REG_BSEL_SIZE-1:0] req_wben_i,
    input  logic [TCU_REG_ADDR_SIZE-1:0] req_addr_i,
    input  logic [TCU_REG_DATA_SIZE-1:0] req_wdata_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [TCU_REG_DATA_SIZE-1:0] resp_rdata_o,
    output logic                         resp_write_o,
    input  logic                         boot_start_i,
    output logic                         boot_busy_o,
    output logic                         boot_done_o,
    output logic                         config_en_o,
    output logic [TCU_REG_BSEL_SIZE-1:0] config_wben_o,
    output logic [TCU_REG_ADDR_SIZE-1:0] config_addr_o,
    output logic [TCU_REG_DATA_SIZE-1:0] config_wdata_o,
    input  logic [TCU_REG_DATA_SIZE-1:0] config_rdata_i
);

    localparam int CNT_MAX = (READ_LATENCY > INT1_PULSE_CYCLES) ? READ_LATENCY : INT1_PULSE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] RESP    = 3'd3;
    localparam logic [2:0] B_EN    = 3'd4;
    localparam logic [2:0] B_SET   = 3'd5;
    localparam logic [2:0] B_HOLD  = 3'd6;
    localparam logic [2:0] B_CLR   = 3'd7;

    localparam logic [TCU_REG_BSEL_SIZE-1:0] BOOT_WBEN = TCU_REG_BSEL_SIZE'(1);
    localparam logic [TCU_REG_DATA_SIZE-1:0] DATA_ONE  = TCU_REG_DATA_SIZE'(1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             boot_pending;
    logic             active;
    logic             boot_state;
    logic             boot_arm;

    assign boot_state  = (state == B_EN) || (state == B_SET) || (state == B_HOLD) || (state == B_CLR);
    assign boot_busy_o = boot_pending || boot_state;
    // active keeps req_ready_o low while reset is asserted, even though the FSM sits in IDLE
    assign req_ready_o = active && (state == IDLE) && !boot_pending && !boot_start_i;
    // pulses during B_EN..B_HOLD collapse into the running boot; a pulse in B_CLR re-arms
    assign boot_arm    = boot_start_i &&
                         ((state == ISSUE) || (state == RD_WAIT) || (state == RESP) || (state == B_CLR));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state          <= IDLE;
            cnt            <= '0;
            boot_pending   <= 1'b0;
            active         <= 1'b0;
            resp_valid_o   <= 1'b0;
            resp_rdata_o   <= '0;
            resp_write_o   <= 1'b0;
            boot_done_o    <= 1'b0;
            config_en_o    <= 1'b0;
            config_wben_o  <= '0;
            config_addr_o  <= '0;
            config_wdata_o <= '0;
        end else begin
            active         <= 1'b1;
            config_en_o    <= 1'b0;
            config_wben_o  <= '0;
            config_addr_o  <= '0;
            config_wdata_o <= '0;
            boot_done_o    <= 1'b0;

            case (state)
                IDLE: begin
                    if (boot_pending || boot_start_i) begin
                        boot_pending   <= 1'b0;
                        state          <= B_EN;
                        config_en_o    <= 1'b1;
                        config_wben_o  <= BOOT_WBEN;
                        config_addr_o  <= REG_EN_ADDR;
                        config_wdata_o <= DATA_ONE;
                    end else if (req_valid_i && req_ready_o) begin
                        state          <= ISSUE;
                        config_en_o    <= 1'b1;
                        config_wben_o  <= req_wben_i;
                        config_addr_o  <= req_addr_i;
                        config_wdata_o <= req_wdata_i;
                    end
                end
                // the strobe registers double as the captured request during ISSUE
                ISSUE: begin
                    if (config_wben_o != '0) begin
                        state        <= RESP;
                        resp_valid_o <= 1'b1;
                        resp_write_o <= 1'b1;
                        resp_rdata_o <= '0;
                    end else begin
                        cnt   <= CNT_W'(READ_LATENCY);
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state        <= RESP;
                        resp_valid_o <= 1'b1;
                        resp_write_o <= 1'b0;
                        resp_rdata_o <= config_rdata_i;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b0;
                        resp_write_o <= 1'b0;
                        resp_rdata_o <= '0;
                    end
                end
                B_EN: begin
                    state          <= B_SET;
                    config_en_o    <= 1'b1;
                    config_wben_o  <= BOOT_WBEN;
                    config_addr_o  <= REG_INT1_ADDR;
                    config_wdata_o <= DATA_ONE;
                end
                B_SET: begin
                    state <= B_HOLD;
                    cnt   <= CNT_W'(INT1_PULSE_CYCLES);
                end
                B_HOLD: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state          <= B_CLR;
                        config_en_o    <= 1'b1;
                        config_wben_o  <= BOOT_WBEN;
                        config_addr_o  <= REG_INT1_ADDR;
                        config_wdata_o <= '0;
                        boot_done_o    <= 1'b1;
                    end
                end
                B_CLR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (boot_arm) begin
                boot_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_boom_config_master.sv
// Scoreboard bench for boom_config_master: strobes and responses are matched against
// queued expectations; a second READ_LATENCY=4 instance covers reset during a read.
`timescale 1ns/1ps
module tb_boom_config_master;

    localparam logic [63:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

    typedef struct packed {
        logic [7:0]  wben;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        done;
    } cfg_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        write;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [7:0]  req_wben = '0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_ready = 1'b1;
    logic        boot_start = 1'b0;
    logic        req_ready, resp_valid, resp_write, boot_busy, boot_done, config_en;
    logic [63:0] resp_rdata, config_wdata, config_rdata;
    logic [7:0]  config_wben;
    logic [31:0] config_addr;

    logic        rst_n4 = 1'b0;
    logic        req_valid4 = 1'b0;
    logic [31:0] req_addr4 = '0;
    logic        resp_ready4 = 1'b1;
    logic        boot_start4 = 1'b0;
    logic        req_ready4, resp_valid4, resp_write4, boot_busy4, boot_done4, config_en4;
    logic [63:0] resp_rdata4, config_wdata4, config_rdata4;
    logic [7:0]  config_wben4;
    logic [31:0] config_addr4;

    int checks = 0;
    int errors = 0;
    cfg_t cfgQ[$];
    rsp_t rspQ[$];
    cfg_t monCfg;
    rsp_t monRsp;

    boom_config_master #(
        .TCU_REG_ADDR_SIZE(32), .TCU_REG_DATA_SIZE(64), .TCU_REG_BSEL_SIZE(8),
        .READ_LATENCY(1), .INT1_PULSE_CYCLES(16),
        .REG_EN_ADDR(32'h0), .REG_INT1_ADDR(32'h8)
    ) u_dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_wben_i(req_wben), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_write_o(resp_write),
        .boot_start_i(boot_start), .boot_busy_o(boot_busy), .boot_done_o(boot_done),
        .config_en_o(config_en), .config_wben_o(config_wben), .config_addr_o(config_addr),
        .config_wdata_o(config_wdata), .config_rdata_i(config_rdata)
    );

    boom_config_master #(
        .TCU_REG_ADDR_SIZE(32), .TCU_REG_DATA_SIZE(64), .TCU_REG_BSEL_SIZE(8),
        .READ_LATENCY(4), .INT1_PULSE_CYCLES(2),
        .REG_EN_ADDR(32'h0), .REG_INT1_ADDR(32'h8)
    ) u_dut4 (
        .clk_i(clk), .reset_n_i(rst_n4),
        .req_valid_i(req_valid4), .req_ready_o(req_ready4),
        .req_wben_i(8'h00), .req_addr_i(req_addr4), .req_wdata_i(64'h0),
        .resp_valid_o(resp_valid4), .resp_ready_i(resp_ready4),
        .resp_rdata_o(resp_rdata4), .resp_write_o(resp_write4),
        .boot_start_i(boot_start4), .boot_busy_o(boot_busy4), .boot_done_o(boot_done4),
        .config_en_o(config_en4), .config_wben_o(config_wben4), .config_addr_o(config_addr4),
        .config_wdata_o(config_wdata4), .config_rdata_i(config_rdata4)
    );

    function automatic logic [63:0] slaveData(input logic [31:0] a);
        if (a == 32'h48) return 64'hDEAD_BEEF;
        return {32'hC0DE_0000, a};
    endfunction

    // Slaves drive valid data only in the exact cycle READ_LATENCY after a read strobe
    logic        sv1 = 1'b0;
    logic [31:0] sa1 = '0;
    logic [3:0]  sh4 = '0;
    logic [31:0] sa4 = '0;
    always @(posedge clk) begin
        sv1 <= config_en && (config_wben == 8'h00);
        if (config_en) sa1 <= config_addr;
        sh4 <= {sh4[2:0], config_en4 && (config_wben4 == 8'h00)};
        if (config_en4) sa4 <= config_addr4;
    end
    assign config_rdata  = sv1 ? slaveData(sa1) : GARBAGE;
    assign config_rdata4 = sh4[3] ? slaveData(sa4) : GARBAGE;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic pushBoot();
        cfgQ.push_back('{8'h01, 32'h0, 64'd1, 1'b0});
        cfgQ.push_back('{8'h01, 32'h8, 64'd1, 1'b0});
        cfgQ.push_back('{8'h01, 32'h8, 64'd0, 1'b1});
    endtask

    // Called and returns at posedge+1; holds the request until accepted
    task automatic applyStimulus(input logic [7:0] wben, input logic [31:0] addr, input logic [63:0] wdata,
                                 input logic [63:0] expRdata, input logic withBoot, output int waitCycles);
        logic accepted;
        int n;
        accepted = 1'b0;
        n = 0;
        req_valid = 1'b1;
        req_wben = wben;
        req_addr = addr;
        req_wdata = wdata;
        if (withBoot) begin
            boot_start = 1'b1;
            pushBoot();
        end
        while (!accepted && n < 60) begin
            @(negedge clk);
            accepted = req_ready;
            @(posedge clk);
            #1;
            boot_start = 1'b0;
            n++;
        end
        req_valid = 1'b0;
        req_wben = '0;
        req_addr = '0;
        req_wdata = '0;
        checkOutput("accept_within_budget", accepted, 1'b1);
        if (accepted) begin
            cfgQ.push_back('{wben, addr, wdata, 1'b0});
            rspQ.push_back('{(wben != 8'h00) ? 64'd0 : expRdata, wben != 8'h00});
        end
        waitCycles = n;
    endtask

    task automatic applyStimulusLat4(input logic [31:0] addr);
        logic accepted;
        accepted = 1'b0;
        req_valid4 = 1'b1;
        req_addr4 = addr;
        for (int n = 0; n < 20 && !accepted; n++) begin
            @(negedge clk);
            accepted = req_ready4;
            @(posedge clk);
            #1;
        end
        req_valid4 = 1'b0;
        req_addr4 = '0;
        checkOutput("lat4_accept", accepted, 1'b1);
    endtask

    // Monitor: every strobe and every response handshake must match the next queued item
    always @(negedge clk) begin
        if (rst_n) begin
            if (config_en) begin
                checks++;
                if (cfgQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL cfg_unexpected: got strobe addr %0h wdata %0h, want none", config_addr, config_wdata);
                end else begin
                    checks--;
                    monCfg = cfgQ.pop_front();
                    checkOutput("cfg_strobe", {config_wben, config_addr, config_wdata, boot_done}, monCfg);
                end
            end else begin
                checkOutput("cfg_idle_zero", {config_wben, config_addr, config_wdata, boot_done}, 128'd0);
            end
            if (resp_valid && resp_ready) begin
                checks++;
                if (rspQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rsp_unexpected: got rdata %0h write %0b, want none", resp_rdata, resp_write);
                end else begin
                    checks--;
                    monRsp = rspQ.pop_front();
                    checkOutput("resp", {resp_rdata, resp_write}, monRsp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctrl", {req_ready, resp_valid, resp_write, boot_busy, boot_done, config_en, config_wben, config_addr}, 128'd0);
        checkOutput("reset_data", {resp_rdata, config_wdata}, 128'd0);
        checkOutput("reset_lat4", {req_ready4, resp_valid4, boot_busy4, config_en4, config_addr4}, 128'd0);
        rst_n = 1'b1;
        rst_n4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Write: strobe the cycle after acceptance, response the cycle after that
        applyStimulus(8'h01, 32'h40, 64'd1, 64'd0, 1'b0, n);
        @(negedge clk);
        checkOutput("wr_strobe_timing", config_en, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("wr_resp_timing", {resp_valid, resp_write, resp_rdata}, {1'b1, 1'b1, 64'd0});
        @(posedge clk); #1;

        // Read with a stalled consumer
        resp_ready = 1'b0;
        applyStimulus(8'h00, 32'h48, 64'd0, 64'hDEAD_BEEF, 1'b0, n);
        @(negedge clk);
        checkOutput("rd_strobe", {config_en, config_addr}, {1'b1, 32'h48});
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rd_wait_no_resp", resp_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rd_resp", {resp_valid, resp_write, resp_rdata}, {1'b1, 1'b0, 64'hDEAD_BEEF});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("rd_stall_hold", {resp_valid, resp_write, resp_rdata}, {1'b1, 1'b0, 64'hDEAD_BEEF});
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rd_resp_cleared", {resp_valid, resp_rdata, req_ready}, {1'b0, 64'd0, 1'b1});
        @(posedge clk); #1;

        // Boot from IDLE: strobes at cycles 1, 2 and 19, done with the last
        boot_start = 1'b1;
        pushBoot();
        @(posedge clk); #1;
        boot_start = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            checkOutput($sformatf("boot_seq_%0d", i), {config_en, boot_done, req_ready, boot_busy},
                        {(i == 1 || i == 2 || i == 19), (i == 19), 1'b0, 1'b1});
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput("boot_finished", {boot_busy, req_ready}, {1'b0, 1'b1});
        @(posedge clk); #1;

        // Boot and request together: boot wins, request accepted right after
        applyStimulus(8'hFF, 32'h100, 64'h1234, 64'd0, 1'b1, n);
        checkOutput("boot_then_req_cycles", n, 21);
        @(negedge clk);
        checkOutput("boot_then_req_strobe", config_en, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end

        // Boot requested while a response is stalled
        resp_ready = 1'b0;
        applyStimulus(8'h00, 32'h60, 64'd0, slaveData(32'h60), 1'b0, n);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("resp_before_boot", resp_valid, 1'b1);
        @(posedge clk); #1;
        boot_start = 1'b1;
        pushBoot();
        @(posedge clk); #1;
        boot_start = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_pulse_in_resp", {boot_busy, resp_valid, config_en}, {1'b1, 1'b1, 1'b0});
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("idle_before_pending_boot", {resp_valid, config_en, boot_busy, req_ready}, {1'b0, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("pending_boot_start", config_en, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            seen = boot_done;
        end
        checkOutput("pending_boot_done", seen, 1'b1);
        @(posedge clk); #1;

        // Pulse in B_HOLD collapses; pulse in B_CLR triggers a second boot
        boot_start = 1'b1;
        pushBoot();
        pushBoot();
        @(posedge clk); #1;
        boot_start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        boot_start = 1'b1;
        @(posedge clk); #1;
        boot_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        boot_start = 1'b1;
        @(posedge clk); #1;
        boot_start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!boot_busy) break;
            @(posedge clk); #1;
        end
        checkOutput("double_boot_idle", boot_busy, 1'b0);
        checkOutput("double_boot_drained", cfgQ.size(), 0);
        repeat (4) begin
            @(posedge clk); #1;
        end

        // READ_LATENCY=4 instance: reset in RD_WAIT, then a clean read
        applyStimulusLat4(32'h50);
        @(negedge clk);
        checkOutput("lat4_strobe", config_en4, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n4 = 1'b0;
        #1;
        checkOutput("lat4_reset_ctrl", {req_ready4, resp_valid4, resp_write4, boot_busy4, boot_done4, config_en4, config_wben4, config_addr4}, 128'd0);
        checkOutput("lat4_reset_data", {resp_rdata4, config_wdata4}, 128'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n4 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("lat4_no_stale_resp", {resp_valid4, config_en4}, 2'b00);
            @(posedge clk); #1;
        end
        applyStimulusLat4(32'h58);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) checkOutput("lat4_strobe2", {config_en4, config_addr4}, {1'b1, 32'h58});
            else if (i < 6) checkOutput("lat4_wait", resp_valid4, 1'b0);
            else checkOutput("lat4_resp", {resp_valid4, resp_write4, resp_rdata4}, {1'b1, 1'b0, slaveData(32'h58)});
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput("lat4_resp_cleared", resp_valid4, 1'b0);
        @(posedge clk); #1;

        checkOutput("cfg_queue_empty", cfgQ.size(), 0);
        checkOutput("rsp_queue_empty", rspQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
